user_event_sched: RTL

Schedules the single user-event stream into `main_game_logic`. Merges key events from the input decoder (buffered in a small FIFO) with an internally generated gravity `EV_DOWN` tick whose period shrinks with game level. Drives the existing `user_event_i / user_event_ready_i / user_event_rd_req_o` handshake of `main_game_logic` from the producer side. Sits between the keyboard/button decoder and `main_game_logic`.

---
 rtl/user_event_sched_pkg.sv | 15 +
 rtl/user_event_fifo.sv | 52 +++++
 rtl/user_event_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/user_event_sched_pkg.sv
// Shared definitions for the user-event scheduler: the event encoding consumed
// by main_game_logic and the level input width.
package user_event_sched_pkg;

    typedef enum logic [2:0] {
        EV_NEW_GAME = 3'd0,
        EV_LEFT     = 3'd1,
        EV_RIGHT    = 3'd2,
        EV_DOWN     = 3'd3,
        EV_ROTATE   = 3'd4
    } user_event_t;

    localparam int unsigned LEVEL_W = 4;

endpackage

// File: rtl/user_event_fifo.sv
// Small synchronous key-event FIFO with wrap-bit pointers and a flush that can
// be combined with a push, leaving exactly the pushed entry.
module user_event_fifo
    import user_event_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_flush,
    input  user_event_t i_data,
    output user_event_t o_data,
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    user_event_t   r_mem [DEPTH];
    logic [AW-1:0] w_wr_idx;

    assign w_wr_idx = i_flush ? '0 : r_wr_ptr[AW-1:0];
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data   = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= i_push ? PTR_ONE : '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[w_wr_idx] <= i_data;
    end

endmodule

// File: rtl/user_event_sched.sv
// user_event_sched: merges buffered key events with a level-dependent gravity
// EV_DOWN tick into the single user-event handshake of main_game_logic.
module user_event_sched
    import user_event_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned GRAVITY_TICKS = 50_000_000,
    parameter int unsigned GRAVITY_STEP  = 4_000_000,
    parameter int unsigned GRAVITY_MIN   = 5_000_000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  user_event_t        key_event_i,
    input  logic               key_valid_i,
    input  logic               game_active_i,
    input  logic               pause_i,
    input  logic [LEVEL_W-1:0] level_i,
    output user_event_t        user_event_o,
    output logic               user_event_ready_o,
    input  logic               user_event_rd_req_i,
    output logic               key_drop_o
);

    localparam int unsigned    PW      = CNT_W + 4;
    localparam logic [PW-1:0]  P_TICKS = PW'(GRAVITY_TICKS);
    localparam logic [PW-1:0]  P_STEP  = PW'(GRAVITY_STEP);
    localparam logic [PW-1:0]  P_MIN   = PW'(GRAVITY_MIN);
    localparam logic [PW-1:0]  P_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    user_event_t      r_event;
    logic             r_rr_key;
    logic             r_key_drop;
    logic [CNT_W-1:0] r_grav_cnt;
    logic             r_grav_pend;

    logic [PW-1:0]    w_reduction;
    logic [PW-1:0]    w_period;
    logic [PW-1:0]    w_last;
    logic             w_cnt_run;
    logic             w_tick;

    user_event_t      w_fifo_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_blocked;
    logic             w_flush;
    logic             w_drop;
    logic             w_push;

    logic             w_load;
    logic             w_pop;
    logic             w_grav_clr;
    logic             w_flip;
    user_event_t      w_sel;

    // Period is formed in a wider domain so level*step can never wrap below the floor.
    always_comb begin
        w_reduction = PW'(level_i) * P_STEP;
        if ((w_reduction >= P_TICKS) || ((P_TICKS - w_reduction) < P_MIN)) begin
            w_period = P_MIN;
        end else begin
            w_period = P_TICKS - w_reduction;
        end
    end

    assign w_last    = w_period - P_ONE;
    assign w_cnt_run = game_active_i && !pause_i;
    assign w_tick    = (PW'(r_grav_cnt) >= w_last);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_grav_cnt  <= '0;
            r_grav_pend <= 1'b0;
        end else if (!game_active_i) begin
            r_grav_cnt  <= '0;
            r_grav_pend <= 1'b0;
        end else begin
            if (w_cnt_run) r_grav_cnt <= w_tick ? '0 : r_grav_cnt + CNT_ONE;
            r_grav_pend <= (r_grav_pend && !w_grav_clr) || (w_cnt_run && w_tick);
        end
    end

    // A full FIFO still accepts a push when the scheduler pops in the same cycle.
    assign w_blocked = key_valid_i && w_fifo_full && !w_pop;
    assign w_flush   = w_blocked && (key_event_i == EV_NEW_GAME);
    assign w_drop    = w_blocked && (key_event_i != EV_NEW_GAME);
    assign w_push    = key_valid_i && !w_drop;

    user_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (key_event_i),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_grav_clr  = 1'b0;
        w_flip      = 1'b0;
        w_sel       = EV_DOWN;
        case (r_state)
            ST_IDLE: begin
                if (!pause_i) begin
                    if (!w_fifo_empty && (w_fifo_head == EV_NEW_GAME)) begin
                        w_load     = 1'b1;
                        w_pop      = 1'b1;
                        w_grav_clr = 1'b1;
                        w_sel      = EV_NEW_GAME;
                    end else if (!w_fifo_empty && r_grav_pend) begin
                        w_load     = 1'b1;
                        w_flip     = 1'b1;
                        w_pop      = r_rr_key;
                        w_grav_clr = !r_rr_key;
                        w_sel      = r_rr_key ? w_fifo_head : EV_DOWN;
                    end else if (!w_fifo_empty) begin
                        w_load = 1'b1;
                        w_pop  = 1'b1;
                        w_sel  = w_fifo_head;
                    end else if (r_grav_pend) begin
                        w_load     = 1'b1;
                        w_grav_clr = 1'b1;
                    end
                    if (w_load) w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: if (user_event_rd_req_i) w_state_nxt = ST_GAP;
            ST_GAP:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_event    <= EV_DOWN;
            r_rr_key   <= 1'b1;
            r_key_drop <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_key_drop <= w_drop;
            if (w_load) r_event  <= w_sel;
            if (w_flip) r_rr_key <= !r_rr_key;
        end
    end

    assign user_event_o       = r_event;
    assign user_event_ready_o = (r_state == ST_PRESENT);
    assign key_drop_o         = r_key_drop;

endmodule
